// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream FIFO: 8N1 framing, LSB first,
// CLKS_PER_BIT clocks per bit. All outputs are registered.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       empty,
    input  logic [7:0] fifo_dout,
    output logic       rden,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          rden_n, tx_n, busy_n, tx_done_n;
    logic          bit_end;

    assign bit_end = (cnt == LAST);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        case (state)
            IDLE:  if (enable && !empty) state_n = FETCH;
            FETCH: state_n = LOAD;
            LOAD: begin
                shreg_n = fifo_dout;
                cnt_n   = '0;
                state_n = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_n     = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are derived from the next state so the registered copies line up with it.
        rden_n    = (state_n == FETCH);
        busy_n    = (state_n != IDLE);
        tx_done_n = (state_n == STOP) && (cnt_n == LAST);
        tx_n      = 1'b1;
        if (state_n == START) tx_n = 1'b0;
        if (state_n == DATA)  tx_n = shreg_n[0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            rden    <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            rden    <= rden_n;
            tx      <= tx_n;
            busy    <= busy_n;
            tx_done <= tx_done_n;
        end
    end

endmodule
